// File: rtl/trace_line_parser.sv
// ASCII trace-line parser: "<op> <hex addr><CR|LF>" -> cache command, one err_pulse per bad line.
// Optional TRACE_ERR_CNT_EN adds a saturating 16-bit err_count output.
module trace_line_parser #(
  parameter int MAX_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  output logic        cmd_valid,
  output logic [3:0]  cmd_op,
  output logic [31:0] cmd_addr,
  input  logic        cmd_ready,
  output logic        err_pulse,
  output logic        busy
`ifdef TRACE_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;

  typedef enum logic [2:0] {IDLE, SEP, WS, ADDR, EMIT, SKIP} state_t;

  state_t         state_reg, state_next;
  logic [31:0]    acc_reg, acc_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [3:0]     op_reg, op_next;
  logic           err_reg, err_next;

  logic           accept;
  logic           is_dec, is_hex, is_blank;
  logic [3:0]     hex_val;

  assign accept   = ch_valid && ch_ready;
  assign is_blank = (ch_data == CH_SP) || (ch_data == CH_TAB);
  assign is_dec   = (ch_data >= 8'h30) && (ch_data <= 8'h39);

  // Letters: the low nibble of 'A'..'F' and 'a'..'f' is 1..6, so +9 gives 10..15.
  always_comb begin
    is_hex  = 1'b0;
    hex_val = 4'd0;
    if (is_dec) begin
      is_hex  = 1'b1;
      hex_val = ch_data[3:0];
    end else if (((ch_data >= 8'h41) && (ch_data <= 8'h46)) ||
                 ((ch_data >= 8'h61) && (ch_data <= 8'h66))) begin
      is_hex  = 1'b1;
      hex_val = ch_data[3:0] + 4'd9;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= 32'd0;
      cnt_reg   <= '0;
      op_reg    <= 4'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: if (accept) begin
        if (is_dec) begin
          op_next    = ch_data[3:0];
          state_next = SEP;
        end else if (!(is_blank || ch_data == CH_CR || ch_data == CH_LF)) begin
          err_next   = 1'b1;
          state_next = SKIP;
        end
      end
      SEP: if (accept) begin
        if (is_blank) begin
          state_next = WS;
        end else begin
          err_next   = 1'b1;
          state_next = (ch_data == CH_LF) ? IDLE : SKIP;
        end
      end
      WS: if (accept) begin
        if (is_hex) begin
          acc_next   = {28'd0, hex_val};
          cnt_next   = CW'(1);
          state_next = ADDR;
        end else if (!is_blank) begin
          err_next   = 1'b1;
          state_next = (ch_data == CH_LF) ? IDLE : SKIP;
        end
      end
      ADDR: if (accept) begin
        if (is_hex && (cnt_reg != CW'(MAX_DIGITS))) begin
          acc_next = {acc_reg[27:0], hex_val};
          cnt_next = cnt_reg + CW'(1);
        end else if (ch_data == CH_CR || ch_data == CH_LF) begin
          state_next = EMIT;
        end else begin
          err_next   = 1'b1;
          state_next = SKIP;
        end
      end
      EMIT: if (cmd_ready) state_next = IDLE;
      SKIP: if (accept && ch_data == CH_LF) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ch_ready  = (state_reg != EMIT);
    cmd_valid = (state_reg == EMIT);
    busy      = (state_reg != IDLE);
    err_pulse = err_reg;
    cmd_op    = cmd_valid ? op_reg : 4'd0;
    cmd_addr  = cmd_valid ? acc_reg : 32'd0;
  end

`ifdef TRACE_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 16'd0;
    end else if (err_reg && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trace_line_parser.sv
// Self-checking bench for trace_line_parser: directed line table, stall/reset sequences,
// and random lines whose expected result follows from how each line was generated.
module tb_trace_line_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic        cmd_valid;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic        cmd_ready;
  logic        err_pulse;
  logic        busy;
`ifdef TRACE_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  trace_line_parser #(.MAX_DIGITS(8)) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_ready(cmd_ready),
    .err_pulse(err_pulse), .busy(busy)
`ifdef TRACE_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulse_total = 0;
  int pulses_since_rst = 0;
  int line_no = 0;
  bit ready_rand = 1'b0;
  logic [3:0]  got_op[$];
  logic [31:0] got_addr[$];
  bit          stall_pending = 1'b0;
  logic [3:0]  stall_op;
  logic [31:0] stall_addr;

  typedef struct {
    string       line;
    bit          exp_err;
    bit          exp_cmd;
    logic [3:0]  op;
    logic [31:0] addr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: collects handshakes and pulses, checks EMIT holds steady while stalled.
  always @(negedge clk) begin
    if (rst) begin
      stall_pending = 1'b0;
      pulses_since_rst = 0;
    end else begin
      if (err_pulse) begin
        pulse_total++;
        pulses_since_rst++;
      end
      if (stall_pending) begin
        check("stall_valid", 32'(cmd_valid), 32'd1);
        check("stall_op", 32'(cmd_op), 32'(stall_op));
        check("stall_addr", cmd_addr, stall_addr);
      end
      stall_pending = 1'b0;
      if (cmd_valid) begin
        check("emit_ch_ready", 32'(ch_ready), 32'd0);
        if (cmd_ready) begin
          got_op.push_back(cmd_op);
          got_addr.push_back(cmd_addr);
        end else begin
          stall_pending = 1'b1;
          stall_op = cmd_op;
          stall_addr = cmd_addr;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_rand) cmd_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_char(input logic [7:0] c);
    int n;
    bit done;
    repeat ($urandom_range(0, 2)) begin
      ch_valid = 1'b0;
      ch_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    ch_valid = 1'b1;
    ch_data = c;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      done = ch_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 300) begin
        check("ch_ready_timeout", 32'(ch_ready), 32'd1);
        done = 1'b1;
      end
    end
    ch_valid = 1'b0;
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_line(input string s, input bit exp_err, input bit exp_cmd,
                          input logic [3:0] op, input logic [31:0] addr);
    int p0;
    int q0;
    p0 = pulse_total;
    q0 = got_op.size();
    send_line(s);
    wait_idle();
    line_no++;
    check("err_pulses", 32'(pulse_total - p0), 32'(exp_err));
    check("cmd_count", 32'(got_op.size() - q0), 32'(exp_cmd));
    if (exp_cmd && got_op.size() > q0) begin
      check("cmd_op", 32'(got_op[q0]), 32'(op));
      check("cmd_addr", got_addr[q0], addr);
    end
    $display("line %0d: len=%0d exp_err=%0d exp_cmd=%0d op=%0d addr=%h pulses=%0d cmds=%0d",
             line_no, s.len(), exp_err, exp_cmd, op, addr, pulse_total - p0, got_op.size() - q0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_cmd_op"}, 32'(cmd_op), 32'd0);
    check({tag, "_cmd_addr"}, cmd_addr, 32'd0);
    check({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic random_line();
    string       s;
    int unsigned kind, n, nib, op;
    logic [7:0]  b;
    logic [31:0] v;
    bit          bad;
    s = "";
    if ($urandom_range(0, 3) == 0) s = " ";
    kind = $urandom_range(0, 7);
    n = $urandom_range(1, 10);
    op = $urandom_range(0, 9);
    if (kind == 0) begin
      case ($urandom_range(0, 2))
        0: b = 8'h78;
        1: b = 8'h67;
        default: b = 8'h23;
      endcase
    end else begin
      b = 8'(8'h30 + op);
    end
    s = $sformatf("%s%c", s, b);
    if (kind != 3) begin
      repeat ($urandom_range(1, 3)) s = {s, ($urandom_range(0, 1) == 1) ? " " : "\t"};
    end
    v = 32'd0;
    if (kind != 2) begin
      for (int j = 0; j < int'(n); j++) begin
        nib = $urandom_range(0, 15);
        if (kind == 1 && j == int'(n / 2)) begin
          b = 8'h7A;
        end else if (nib < 10) begin
          b = 8'(8'h30 + nib);
        end else begin
          b = 8'((($urandom_range(0, 1) == 1) ? 8'h41 : 8'h61) + nib - 10);
        end
        s = $sformatf("%s%c", s, b);
        v = v * 16 + nib;
      end
    end
    s = {s, ($urandom_range(0, 1) == 1) ? "\015\n" : "\n"};
    bad = (kind < 4) || (n > 8);
    run_line(s, bad, !bad, 4'(op), v);
  endtask

  initial begin
    vec_t vecs[10];
    int   p0;
    int   q0;
    vecs[0] = '{"2 A5F3C9B2\n",     1'b0, 1'b1, 4'd2, 32'hA5F3C9B2};
    vecs[1] = '{"0 1a2b\015\n",     1'b0, 1'b1, 4'd0, 32'h00001A2B};
    vecs[2] = '{"1 123456789\n",    1'b1, 1'b0, 4'd0, 32'h0};
    vecs[3] = '{"8 FFFFFFFF\n",     1'b0, 1'b1, 4'd8, 32'hFFFFFFFF};
    vecs[4] = '{"x 10\n",           1'b1, 1'b0, 4'd0, 32'h0};
    vecs[5] = '{"5 0\n",            1'b0, 1'b1, 4'd5, 32'h0};
    vecs[6] = '{" \t9\t\tfFeE\n",   1'b0, 1'b1, 4'd9, 32'h0000FFEE};
    vecs[7] = '{"7\n",              1'b1, 1'b0, 4'd0, 32'h0};
    vecs[8] = '{"4 \n",             1'b1, 1'b0, 4'd0, 32'h0};
    vecs[9] = '{"6 12G4\n",         1'b1, 1'b0, 4'd0, 32'h0};

    rst = 1'b1;
    ch_valid = 1'b0;
    ch_data = 8'h00;
    cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ch_ready", 32'(ch_ready), 32'd1);
    @(posedge clk);
    #1;

    cmd_ready = 1'b1;
    for (int i = 0; i < 10; i++)
      run_line(vecs[i].line, vecs[i].exp_err, vecs[i].exp_cmd, vecs[i].op, vecs[i].addr);

    // Downstream stall: command must hold for 5 cycles with input blocked.
    cmd_ready = 1'b0;
    q0 = got_op.size();
    send_line("3 10\n");
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", 32'(cmd_valid), 32'd1);
      check("hold_op", 32'(cmd_op), 32'd3);
      check("hold_addr", cmd_addr, 32'h10);
      check("hold_ch_ready", 32'(ch_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    wait_idle();
    check("hold_cmd_count", 32'(got_op.size() - q0), 32'd1);
    run_line("6 1\n", 1'b0, 1'b1, 4'd6, 32'h1);

    // Reset in the middle of a line: no pulse, partial line dropped.
    p0 = pulse_total;
    send_line("3 AB");
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midline_rst");
    @(negedge clk);
    check_all_zero("midline_rst2");
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_line("4 0\n", 1'b0, 1'b1, 4'd4, 32'h0);
    check("midline_rst_pulses", 32'(pulse_total - p0), 32'd0);

    // Reset while a command waits in EMIT: the command is discarded.
    cmd_ready = 1'b0;
    q0 = got_op.size();
    send_line("7 5\n");
    @(negedge clk);
    check("emit_pending", 32'(cmd_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("emit_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("emit_rst_dropped", 32'(got_op.size() - q0), 32'd0);
    @(posedge clk);
    #1;
    run_line("5 0\n", 1'b0, 1'b1, 4'd5, 32'h0);

    ready_rand = 1'b1;
    for (int i = 0; i < 60; i++) random_line();
    ready_rand = 1'b0;
    cmd_ready = 1'b1;

`ifdef TRACE_ERR_CNT_EN
    @(negedge clk);
    check("err_count", 32'(err_count), 32'(pulses_since_rst));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
